freq_demod_9bit: RTL and testbench

//  Receive-side counterpart of the 9-bit frequency-divider modulator in the digital

---
 rtl/freq_mod_pkg.sv | 30 +++
 rtl/freq_demod_9bit_edge_sync_detect.sv | 35 +++
 rtl/freq_demod_9bit.sv | 186 ++++++++++++++++++
 tb/tb_freq_demod_9bit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mod_pkg.sv
// ============================================================================
// Module  : freq_mod_pkg
// Brief   : Symbol/half-period constants shared by the 9-bit FSK modulator
//           and demodulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package freq_mod_pkg;

    localparam int SYM_W   = 3;
    localparam int CNT_W   = 9;
    localparam int MEAS_W  = CNT_W + 1;
    localparam int HP_BASE = 256;
    localparam int HP_STEP = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Nominal half-period of a symbol, in clk cycles
    function automatic logic [MEAS_W-1:0] hp_of_sym(input logic [SYM_W-1:0] s);
        return MEAS_W'(HP_BASE - HP_STEP * int'(s));
    endfunction

endpackage

`default_nettype wire

// File: rtl/freq_demod_9bit_edge_sync_detect.sv
// ============================================================================
// Module  : edge_sync_detect
// Brief   : Two-flop synchronizer followed by a both-polarity edge pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_sync_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = sync2_q ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/freq_demod_9bit.sv
// ============================================================================
// Module  : freq_demod_9bit
// Brief   : Measures the carrier half-period and recovers the 3-bit symbol.
// Revision: 1.0
// ============================================================================
`default_nettype none

module freq_demod_9bit
    import freq_mod_pkg::*;
#(
    parameter int TOL     = 4,
    parameter int CONFIRM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             locked,
    output logic             err
);

    localparam logic [MEAS_W-1:0] c_TOL     = MEAS_W'(TOL);
    localparam logic [2:0]        c_CONFIRM = 3'(CONFIRM);

    logic              edge_w;
    logic [CNT_W-1:0]  hp_cnt_q, hp_cnt_d;
    state_t            state_q, state_d;
    logic [SYM_W-1:0]  cand_q, cand_d;
    logic [2:0]        mcount_q, mcount_d;
    logic [SYM_W-1:0]  sym_out_q, sym_out_d;
    logic              sym_valid_q, sym_valid_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    edge_sync_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .edge_o (edge_w)
    );

    // ------------------------------------------------------------------
    // Half-period counter
    // ------------------------------------------------------------------
    logic timeout_w;
    assign timeout_w = (hp_cnt_q == '1) && !edge_w;

    always_comb begin
        hp_cnt_d = hp_cnt_q;
        if (edge_w) begin
            hp_cnt_d = '0;
        end else if (hp_cnt_q != '1) begin
            hp_cnt_d = hp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_cnt_q <= '0;
        end else begin
            hp_cnt_q <= hp_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode: round (HP_BASE - measured) to the nearest step
    // ------------------------------------------------------------------
    logic [MEAS_W-1:0]  meas_w;
    logic signed [10:0] d_w;
    logic signed [10:0] s_w;
    logic [SYM_W-1:0]   s_sym_w;
    logic [MEAS_W-1:0]  hp_w;
    logic [MEAS_W-1:0]  diff_w;
    logic               match_w;

    assign meas_w  = {1'b0, hp_cnt_q} + MEAS_W'(1);
    assign d_w     = $signed(11'(HP_BASE)) - $signed({1'b0, meas_w});
    assign s_w     = (d_w + 11'sd16) >>> 5;
    assign s_sym_w = s_w[SYM_W-1:0];
    assign hp_w    = hp_of_sym(s_sym_w);
    assign diff_w  = (meas_w >= hp_w) ? (meas_w - hp_w) : (hp_w - meas_w);
    assign match_w = !s_w[10] && (s_w[9:3] == '0) && (diff_w <= c_TOL);

    logic [2:0] mc_next_w;
    logic       confirm_w;

    always_comb begin
        if (s_sym_w != cand_q) begin
            mc_next_w = 3'd1;
        end else if (mcount_q >= c_CONFIRM) begin
            mc_next_w = c_CONFIRM;
        end else begin
            mc_next_w = mcount_q + 3'd1;
        end
    end

    assign confirm_w = match_w && (mc_next_w == c_CONFIRM);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (edge_w) state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_w && confirm_w) state_d = LOCKED;
                else if (timeout_w)      state_d = IDLE;
            end
            LOCKED: begin
                if (timeout_w) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs and symbol tracking; the first interval after IDLE is
    // never decoded because it started at an unknown time.
    always_comb begin
        cand_d      = cand_q;
        mcount_d    = mcount_q;
        sym_out_d   = sym_out_q;
        locked_d    = locked_q;
        sym_valid_d = 1'b0;
        err_d       = 1'b0;
        if (state_q != IDLE) begin
            if (edge_w) begin
                if (match_w) begin
                    cand_d   = s_sym_w;
                    mcount_d = mc_next_w;
                    if (confirm_w) begin
                        sym_out_d = s_sym_w;
                        locked_d  = 1'b1;
                        if ((state_q == MEASURE) || (s_sym_w != sym_out_q)) begin
                            sym_valid_d = 1'b1;
                        end
                    end
                end else begin
                    err_d    = 1'b1;
                    mcount_d = '0;
                end
            end else if (timeout_w) begin
                locked_d = 1'b0;
                mcount_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q      <= '0;
            mcount_q    <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            mcount_q    <= mcount_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_demod_9bit.sv
// ============================================================================
// Module  : tb_freq_demod_9bit
// Brief   : Self-checking bench: directed tables plus randomized intervals.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_freq_demod_9bit;

    localparam int TOL     = 4;
    localparam int CONFIRM = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic [2:0] sym_out;
    logic       sym_valid;
    logic       locked;
    logic       err;

    freq_demod_9bit #(.TOL(TOL), .CONFIRM(CONFIRM)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .locked    (locked),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int vcnt   = 0;
    int ecnt   = 0;
    int pend   = 0;

    // Pulse-width sensitive: a pulse held two cycles counts twice
    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid) vcnt++;
            if (err)       ecnt++;
        end
    end

    // Reference model state
    int m_sym = 0, m_run = 0, m_last = 0, m_valid = 0, m_err = 0;
    bit m_locked = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Nearest symbol by exhaustive distance search
    function automatic void ref_decode(input int m, output bit ok, output int s);
        int best;
        int hp;
        int dd;
        best = 100000;
        s    = 0;
        for (int k = 0; k < 8; k++) begin
            hp = 256 - 32 * k;
            dd = (m > hp) ? (m - hp) : (hp - m);
            if (dd < best) begin
                best = dd;
                s    = k;
            end
        end
        ok = (best <= TOL);
    endfunction

    task automatic model_interval(input int m);
        bit ok;
        int s;
        ref_decode(m, ok, s);
        if (!ok) begin
            m_err++;
            m_run = 0;
        end else begin
            if (m_run > 0 && s == m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = s;
            end
            if (m_run >= CONFIRM) begin
                if (!m_locked || s != m_sym) m_valid++;
                m_sym    = s;
                m_locked = 1'b1;
            end
        end
    endtask

    task automatic start_carrier();
        @(posedge clk);
        #1 sig_in = ~sig_in;
        pend = 0;
    endtask

    task automatic send(input int m);
        repeat (m - pend) @(posedge clk);
        #1 sig_in = ~sig_in;
        pend = 0;
        model_interval(m);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
        pend += 6;
    endtask

    typedef struct {
        int interval;
        int exp_err;
        int exp_valid;
        int exp_sym;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int bv, be, n, m, k;

        // Each entry: the interval is sent twice, starting from locked on s=4
        tbl[0]  = '{260, 0, 1, 0};
        tbl[1]  = '{261, 2, 0, 0};
        tbl[2]  = '{28,  0, 1, 7};
        tbl[3]  = '{27,  2, 0, 7};
        tbl[4]  = '{128, 0, 1, 4};
        tbl[5]  = '{140, 2, 0, 4};
        tbl[6]  = '{124, 0, 0, 4};
        tbl[7]  = '{132, 0, 0, 4};
        tbl[8]  = '{133, 2, 0, 4};
        tbl[9]  = '{224, 0, 1, 1};
        tbl[10] = '{96,  0, 1, 5};
        tbl[11] = '{100, 0, 0, 5};
        tbl[12] = '{164, 0, 1, 3};
        tbl[13] = '{50,  2, 0, 3};

        // Reset with a toggling input
        rst    = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 sig_in = ~sig_in;
            @(negedge clk);
            check("reset_outputs", int'({sym_out, sym_valid, locked, err}), 0);
        end
        @(posedge clk);
        #1 sig_in = 1'b0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_locked", int'(locked), 0);
        check("post_reset_valid", vcnt, 0);
        check("post_reset_err", ecnt, 0);

        // Lock on HP=128
        start_carrier();
        for (int i = 0; i < 3; i++) send(128);
        settle();
        check("lock128_sym", int'(sym_out), 4);
        check("lock128_locked", int'(locked), 1);
        check("lock128_valid", vcnt, 1);
        check("lock128_err", ecnt, 0);

        // Switch to HP=32, then hold steady
        bv = vcnt;
        send(32);
        send(32);
        settle();
        check("switch32_sym", int'(sym_out), 7);
        check("switch32_valid", vcnt - bv, 1);
        for (int i = 0; i < 20; i++) send(32);
        settle();
        check("steady32_valid", vcnt - bv, 1);
        check("steady32_err", ecnt, 0);

        // Off-grid interval while locked
        send(128);
        send(128);
        settle();
        check("relock128_sym", int'(sym_out), 4);
        bv = vcnt;
        be = ecnt;
        send(140);
        settle();
        check("offgrid_err", ecnt - be, 1);
        check("offgrid_sym", int'(sym_out), 4);
        check("offgrid_locked", int'(locked), 1);
        send(128);
        send(128);
        settle();
        check("offgrid_after_valid", vcnt - bv, 0);

        // Decode table
        for (int i = 0; i < 14; i++) begin
            bv = vcnt;
            be = ecnt;
            send(tbl[i].interval);
            send(tbl[i].interval);
            settle();
            check($sformatf("tbl%0d_err", tbl[i].interval), ecnt - be, tbl[i].exp_err);
            check($sformatf("tbl%0d_valid", tbl[i].interval), vcnt - bv, tbl[i].exp_valid);
            check($sformatf("tbl%0d_sym", tbl[i].interval), int'(sym_out), tbl[i].exp_sym);
            check($sformatf("tbl%0d_locked", tbl[i].interval), int'(locked), 1);
        end
        check("model_sync_valid", vcnt, m_valid);
        check("model_sync_err", ecnt, m_err);

        // Randomized intervals against the reference model
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    k = int'($urandom_range(0, 7));
                    m = 256 - 32 * k + int'($urandom_range(0, 12)) - 6;
                end else begin
                    m = int'($urandom_range(16, 500));
                end
                send(m);
            end
            settle();
            check($sformatf("rand%0d_sym", b), int'(sym_out), m_sym);
            check($sformatf("rand%0d_locked", b), int'(locked), int'(m_locked));
            check($sformatf("rand%0d_valid", b), vcnt, m_valid);
            check($sformatf("rand%0d_err", b), ecnt, m_err);
        end

        // Carrier loss
        send(128);
        send(128);
        n = 0;
        while (locked && n < 700) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 513 && n <= 517) passes++;
        else $display("FAIL timeout_latency: got %0d cycles, expected 513..517", n);
        m_locked = 1'b0;
        m_run    = 0;
        check("timeout_sym_hold", int'(sym_out), 4);
        bv = vcnt;
        start_carrier();
        send(224);
        send(224);
        settle();
        check("restart_sym", int'(sym_out), 1);
        check("restart_locked", int'(locked), 1);
        check("restart_valid", vcnt - bv, 1);

        // Reset in the middle of a measurement
        send(64);
        repeat (20) @(posedge clk);
        #1;
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_outputs", int'({sym_out, sym_valid, locked, err}), 0);
        rst      = 1'b0;
        m_locked = 1'b0;
        m_run    = 0;
        m_sym    = 0;
        start_carrier();
        send(96);
        send(96);
        settle();
        check("midrst_sym", int'(sym_out), 5);
        check("midrst_locked", int'(locked), 1);
        check("midrst_valid", vcnt, m_valid);
        check("midrst_err", ecnt, m_err);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
